// File: rtl/sensor_reg_pkg.sv
// sensor_reg_pkg: address-map constants and sizing helpers for sensor_snapshot_bank (map end depends on SENSOR_STALE_EN)
package sensor_reg_pkg;
  localparam int ADDR_STATUS = 0;
  localparam int ADDR_CH_BASE = 1;
  function automatic int bytes_per_ch(input int ch_w);
    return (ch_w + 7) / 8;
  endfunction
  function automatic int map_end(input int num_ch, input int ch_w);
`ifdef SENSOR_STALE_EN
    return ADDR_CH_BASE + num_ch * bytes_per_ch(ch_w) + (num_ch + 7) / 8;
`else
    return ADDR_CH_BASE + num_ch * bytes_per_ch(ch_w);
`endif
  endfunction
endpackage

// File: rtl/sensor_chan_cap.sv
// sensor_chan_cap: one channel's live register, snapshot shadow with same-edge bypass, and optional SENSOR_STALE_EN age counter and shadow stale bit
module sensor_chan_cap #(
  parameter int CH_W = 24,
  parameter int STALE_LIMIT = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH_W-1:0] i_data,
  input  logic            i_valid,
  input  logic            i_snap,
  output logic [CH_W-1:0] o_shadow
`ifdef SENSOR_STALE_EN
  ,
  output logic            o_stale
`endif
);
  logic [CH_W-1:0] r_live;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_live <= '0;
      o_shadow <= '0;
    end else begin
      if (i_valid) r_live <= i_data;
      if (i_snap) o_shadow <= i_valid ? i_data : r_live;
    end
  end
`ifdef SENSOR_STALE_EN
  localparam int AW = $clog2(STALE_LIMIT + 1);
  logic [AW-1:0] r_age;
  logic w_stale;
  assign w_stale = r_age == AW'(STALE_LIMIT);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= '0;
      o_stale <= 1'b0;
    end else begin
      r_age <= i_valid ? '0 : w_stale ? r_age : r_age + 1'b1;
      if (i_snap) o_stale <= w_stale;
    end
  end
`endif
endmodule

// File: rtl/sensor_snapshot_bank.sv
// sensor_snapshot_bank: live sensor capture with atomic shadow snapshot and coherent byte-wide readout (stale mask built when SENSOR_STALE_EN is defined)
module sensor_snapshot_bank
  import sensor_reg_pkg::*;
#(
  parameter int NUM_CH = 12,
  parameter int CH_W = 24,
  parameter int ADDR_W = 8,
  parameter int STALE_LIMIT = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*CH_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]      ch_valid,
  input  logic                   snap_req,
  output logic                   snap_done,
  output logic [7:0]             snap_seq,
  input  logic                   rd_req,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [7:0]             rd_data,
  output logic                   rd_ack,
  output logic                   rd_err
);
  localparam int BYTES = bytes_per_ch(CH_W);
  localparam int PW = BYTES * 8;
  localparam int MAP_END = map_end(NUM_CH, CH_W);
  logic [7:0] w_bytes [MAP_END];
  logic [7:0] w_byte;
  logic       w_hit;
  if (MAP_END > 2 ** ADDR_W) begin : g_map_check
    $error("sensor_snapshot_bank: address map does not fit in ADDR_W");
  end
  assign w_bytes[ADDR_STATUS] = snap_seq;
`ifdef SENSOR_STALE_EN
  localparam int SB = (NUM_CH + 7) / 8;
  localparam int SW = SB * 8;
  logic [NUM_CH-1:0] w_stale;
  logic [SW-1:0]     w_stale_pad;
  assign w_stale_pad = SW'(w_stale);
  for (genvar b = 0; b < SB; b++) begin : g_stale
    assign w_bytes[ADDR_CH_BASE + NUM_CH*BYTES + b] = w_stale_pad[8*(SB-1-b) +: 8];
  end
`endif
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CH_W-1:0] w_shadow;
    logic [PW-1:0]   w_pad;
    sensor_chan_cap #(.CH_W(CH_W), .STALE_LIMIT(STALE_LIMIT)) u_cap (
      .clk     (clk),
      .rst     (rst),
      .i_data  (ch_data[c*CH_W +: CH_W]),
      .i_valid (ch_valid[c]),
      .i_snap  (snap_req),
      .o_shadow(w_shadow)
`ifdef SENSOR_STALE_EN
      ,
      .o_stale (w_stale[c])
`endif
    );
    assign w_pad = PW'(w_shadow);
    for (genvar b = 0; b < BYTES; b++) begin : g_byte
      assign w_bytes[ADDR_CH_BASE + c*BYTES + b] = w_pad[8*(BYTES-1-b) +: 8];
    end
  end
  assign w_hit = int'(rd_addr) < MAP_END;
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < MAP_END; i++) w_byte = (int'(rd_addr) == i) ? w_bytes[i] : w_byte;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_done <= 1'b0;
      snap_seq <= '0;
      rd_data <= '0;
      rd_ack <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      snap_done <= snap_req;
      if (snap_req) snap_seq <= snap_seq + 8'd1;
      rd_ack <= rd_req;
      if (rd_req) begin
        rd_data <= w_byte;
        rd_err <= !w_hit;
      end
    end
  end
endmodule

// File: doc/sensor_snapshot_bank.md
# sensor_snapshot_bank

Parametrised sensor register bank that captures NUM_CH live sensor channels and atomically copies them into a shadow bank on request. Multi-byte readout through the byte-addressed port is therefore coherent. Sits between the sensor interface front-ends (altimeter, gyro, accelerometer, magnetometer, GPS, airspeed) and the byte-wide host/telemetry read bus. Adds per-channel update strobes, a snapshot sequence counter, defined out-of-range behaviour and optional staleness detection.

## Interface
Parameters:
- NUM_CH, 12: number of sensor channels.
- CH_W, 24: channel width in bits, 1..32. BYTES = ceil(CH_W/8).
- ADDR_W, 8: read address width. Elaboration error if the address map does not fit in 2^ADDR_W.
- STALE_LIMIT, 1000: cycles without an update before a channel is flagged stale. Used only with SENSOR_STALE_EN.

Ports:
- clk in 1: sole clock. All logic updates on its rising edge.
- rst in 1: reset, synchronous, active-high.
- ch_data in NUM_CH*CH_W: flat live data. Channel c occupies bits [c*CH_W +: CH_W].
- ch_valid in NUM_CH: per-channel update strobe. While ch_valid[c] is high, ch_data for channel c is captured on that edge.
- snap_req in 1: single-cycle request to copy all live registers into the shadow bank.
- snap_done out 1: pulses one cycle after the snapshot edge.
- snap_seq out 8: snapshot sequence counter.
- rd_req in 1: read strobe.
- rd_addr in ADDR_W: byte address, sampled while rd_req is high.
- rd_data out 8: registered read data.
- rd_ack out 1: pulses one cycle after rd_req.
- rd_err out 1: valid with rd_ack; high when the address was out of range.

## Operation
- **Live registers:** one per channel, CH_W bits, loaded while ch_valid[c] is high.
- **Snapshot:** while snap_req is high, every shadow[c] loads the live value on the same edge.
  - Bypass: if ch_valid[c] and snap_req are high in the same cycle, shadow[c] takes ch_data directly (the new value).
  - snap_seq increments on each snapshot and wraps 255 -> 0.
  - A snap_req on consecutive cycles performs a snapshot on each cycle.
- **Address map:** all multi-byte fields are MSB first.
  - Address 0: snap_seq.
  - Channel byte b (b = 0 is the MSB) of channel c is at address 1 + c*BYTES + b.
  - Channel data is right-aligned in BYTES*8 bits and zero-extended.
  - Stale mask (SENSOR_STALE_EN only) starts at address 1 + NUM_CH*BYTES and is ceil(NUM_CH/8) bytes long. The first byte holds the highest bits; unused upper bits are 0.
- **Reads:** served from the shadow bank only.
  - If rd_req and snap_req occur in the same cycle, the read returns the pre-snapshot shadow contents.
  - An address at or above the map end returns rd_data = 8'h00 with rd_err = 1.
  - rd_data holds its value between reads.
  - Back-to-back rd_req every cycle is supported with one rd_ack per request.

## Timing
- Read latency: exactly 1 cycle. A request at edge T gives rd_ack, rd_data and rd_err at T+1.
- snap_done is asserted for one cycle, in the cycle after the snapshot edge.
- Reset values:
  - rd_data = 0, rd_ack = 0, rd_err = 0, snap_done = 0, snap_seq = 0.
  - All live and shadow registers = 0.
  - All age counters = 0; the stale mask is 0.
- Reset mid-operation: a read or snapshot requested in the cycle rst is high is discarded. No ack and no done pulse follow it.
- rst has priority over all other inputs.

## Configuration
- SENSOR_STALE_EN defined:
  - Each channel has an age counter, ceil(log2(STALE_LIMIT+1)) bits, that clears on ch_valid[c] and otherwise increments, saturating at STALE_LIMIT.
  - The live stale bit is (age == STALE_LIMIT). It is copied into the shadow stale mask on each snapshot.
  - The stale-mask bytes are readable.
- SENSOR_STALE_EN undefined:
  - No counters are built.
  - The map ends at 1 + NUM_CH*BYTES; stale-mask addresses return 8'h00 with rd_err = 1.

## Structure
- Package sensor_reg_pkg holds:
  - function bytes_per_ch(CH_W);
  - constants ADDR_STATUS = 0 and ADDR_CH_BASE = 1;
  - function map_end(NUM_CH, CH_W), which accounts for SENSOR_STALE_EN.
- Sub-module sensor_chan_cap is instantiated NUM_CH times via generate. It contains the live register, the shadow register with bypass, and the optional age counter and stale bit.
- The top level contains the sequence counter, address decode and read mux, and the output registers.

## Test plan
All scenarios use NUM_CH = 12 and CH_W = 24 (BYTES = 3), with SENSOR_STALE_EN defined unless stated.
- Reset, then a read of address 0 -> rd_data = 8'h00, rd_ack one cycle later, rd_err = 0.
- Load channel 0 = 24'hA1B2C3, snapshot, read addresses 1, 2, 3 back-to-back -> 8'hA1, 8'hB2, 8'hC3 on consecutive cycles; snap_seq = 1; snap_done seen once.
- Change the live channel 0 value to 24'h000001 without a snapshot, read address 3 -> still 8'hC3. Then assert ch_valid and snap_req in the same cycle with 24'h0000FF -> address 3 reads 8'hFF.
- Read addresses 39 and 255 -> rd_data = 8'h00, rd_err = 1.
  - With SENSOR_STALE_EN undefined, address 37 -> rd_err = 1.
- STALE_LIMIT = 10; update only channel 11; wait 12 cycles; snapshot -> address 37 reads 8'h07, address 38 reads 8'hFF.
- Run 256 snapshots -> snap_seq wraps to 0. Assert rst in the same cycle as rd_req -> no rd_ack, and all outputs are 0 on the next cycle.
